// File: rtl/ecc_secded_pipe.sv
// rtl/ecc_secded_pipe.sv - pipelined SECDED encoder/decoder with error counters and first-error log
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   enc_valid_in/enc_data_in      encode request (no backpressure)
//   enc_valid_out/enc_data_out/enc_parity_out   registered encode result, 1 cycle later
//   dec_valid_in/dec_ready_out/dec_data_in/dec_parity_in/bypass   decoder input handshake
//   dec_valid_out/dec_ready_in/dec_data_out      decoder output handshake, 2 cycles latency
//   sbit_err/dbit_err/err_syndrome               per-word status, qualified by dec_valid_out
//   sbit_cnt/dbit_cnt/cnt_clr                    saturating error counters
//   err_log_valid/err_log_syndrome/err_log_clr   first-error syndrome log
module ecc_secded_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int PARITY_WIDTH = 7,
  parameter int CNT_WIDTH    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enc_valid_in,
  input  logic [DATA_WIDTH-1:0]   enc_data_in,
  output logic                    enc_valid_out,
  output logic [DATA_WIDTH-1:0]   enc_data_out,
  output logic [PARITY_WIDTH-1:0] enc_parity_out,
  input  logic                    dec_valid_in,
  output logic                    dec_ready_out,
  input  logic [DATA_WIDTH-1:0]   dec_data_in,
  input  logic [PARITY_WIDTH-1:0] dec_parity_in,
  input  logic                    bypass,
  output logic                    dec_valid_out,
  input  logic                    dec_ready_in,
  output logic [DATA_WIDTH-1:0]   dec_data_out,
  output logic                    sbit_err,
  output logic                    dbit_err,
  output logic [PARITY_WIDTH-1:0] err_syndrome,
  output logic [CNT_WIDTH-1:0]    sbit_cnt,
  output logic [CNT_WIDTH-1:0]    dbit_cnt,
  input  logic                    cnt_clr,
  output logic                    err_log_valid,
  output logic [PARITY_WIDTH-1:0] err_log_syndrome,
  input  logic                    err_log_clr
);

  // Smallest r with 2^r >= DATA_WIDTH + r + 1.
  function automatic int calc_r(input int dw);
    int r;
    r = 1;
    while ((1 << r) < dw + r + 1) r++;
    return r;
  endfunction

  // Codeword position of data bit i: i-th position that is not a power of two.
  function automatic int data_pos(input int i);
    int p, n;
    p = 1;
    n = -1;
    while (n < i) begin
      p++;
      if ((p & (p - 1)) != 0) n++;
    end
    return p;
  endfunction

  // Data bits covered by check bit k.
  function automatic logic [DATA_WIDTH-1:0] check_mask(input int k);
    logic [DATA_WIDTH-1:0] m;
    for (int i = 0; i < DATA_WIDTH; i++) m[i] = ((data_pos(i) >> k) & 1) != 0;
    return m;
  endfunction

  localparam int R = calc_r(DATA_WIDTH);

  if (PARITY_WIDTH != R + 1) begin : g_bad_parity_width
    $error("PARITY_WIDTH must be %0d for DATA_WIDTH=%0d", R + 1, DATA_WIDTH);
  end
  if (DATA_WIDTH < 4) begin : g_bad_data_width
    $error("DATA_WIDTH must be at least 4");
  end

  logic [R-1:0] enc_chk, dec_chk;
  for (genvar k = 0; k < R; k++) begin : g_chk
    localparam logic [DATA_WIDTH-1:0] MASK = check_mask(k);
    assign enc_chk[k] = ^(enc_data_in & MASK);
    assign dec_chk[k] = ^(dec_data_in & MASK);
  end

  // Encoder
  logic                    enc_valid_q;
  logic [DATA_WIDTH-1:0]   enc_data_q;
  logic [PARITY_WIDTH-1:0] enc_parity_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      enc_valid_q  <= 1'b0;
      enc_data_q   <= '0;
      enc_parity_q <= '0;
    end else begin
      enc_valid_q <= enc_valid_in;
      if (enc_valid_in) begin
        enc_data_q   <= enc_data_in;
        enc_parity_q <= {(^enc_data_in) ^ (^enc_chk), enc_chk};
      end
    end
  end

  assign enc_valid_out  = enc_valid_q;
  assign enc_data_out   = enc_data_q;
  assign enc_parity_out = enc_parity_q;

  // Decoder: a single enable freezes both stages while the output is held.
  logic                    en;
  logic                    s1_valid_q, s1_bypass_q, s1_p_q;
  logic [R-1:0]            s1_h_q;
  logic [DATA_WIDTH-1:0]   s1_data_q;
  logic                    out_valid_q, sbit_q, dbit_q;
  logic [DATA_WIDTH-1:0]   out_data_q;
  logic [PARITY_WIDTH-1:0] syn_q;

  assign en            = ~out_valid_q | dec_ready_in;
  assign dec_ready_out = en;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid_q  <= 1'b0;
      s1_bypass_q <= 1'b0;
      s1_p_q      <= 1'b0;
      s1_h_q      <= '0;
      s1_data_q   <= '0;
    end else if (en) begin
      s1_valid_q  <= dec_valid_in;
      s1_bypass_q <= bypass;
      s1_p_q      <= (^dec_data_in) ^ (^dec_parity_in);
      s1_h_q      <= dec_parity_in[R-1:0] ^ dec_chk;
      s1_data_q   <= dec_data_in;
    end
  end

  // One-hot match of the syndrome against every data position.
  logic [DATA_WIDTH-1:0] flip_hit;
  for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_pos
    localparam int POS = data_pos(i);
    assign flip_hit[i] = (s1_h_q == R'(POS));
  end

  logic                    h_pow2;
  logic                    sbit_d, dbit_d;
  logic [DATA_WIDTH-1:0]   data_d;
  logic [PARITY_WIDTH-1:0] syn_d;

  // Zero counts as "power of two" here: p=1 with h=0 is the overall parity bit.
  assign h_pow2 = (s1_h_q & (s1_h_q - R'(1))) == '0;

  always_comb begin
    sbit_d = 1'b0;
    dbit_d = 1'b0;
    data_d = s1_data_q;
    syn_d  = {s1_p_q, s1_h_q};
    if (!s1_valid_q || s1_bypass_q) begin
      syn_d = '0;
    end else if (s1_p_q) begin
      if (h_pow2) begin
        sbit_d = 1'b1;
      end else if (|flip_hit) begin
        sbit_d = 1'b1;
        data_d = s1_data_q ^ flip_hit;
      end else begin
        dbit_d = 1'b1;
      end
    end else if (s1_h_q != '0) begin
      dbit_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      sbit_q      <= 1'b0;
      dbit_q      <= 1'b0;
      out_data_q  <= '0;
      syn_q       <= '0;
    end else if (en) begin
      out_valid_q <= s1_valid_q;
      sbit_q      <= sbit_d;
      dbit_q      <= dbit_d;
      out_data_q  <= data_d;
      syn_q       <= syn_d;
    end
  end

  assign dec_valid_out = out_valid_q;
  assign dec_data_out  = out_data_q;
  assign sbit_err      = sbit_q;
  assign dbit_err      = dbit_q;
  assign err_syndrome  = syn_q;

  // Counters and log act on output transfers only.
  logic                    xfer;
  logic [CNT_WIDTH-1:0]    sbit_cnt_q, sbit_cnt_d, dbit_cnt_q, dbit_cnt_d;
  logic                    log_valid_q, log_valid_d;
  logic [PARITY_WIDTH-1:0] log_syn_q, log_syn_d;

  assign xfer = out_valid_q & dec_ready_in;

  always_comb begin
    sbit_cnt_d  = sbit_cnt_q;
    dbit_cnt_d  = dbit_cnt_q;
    log_valid_d = log_valid_q;
    log_syn_d   = log_syn_q;
    if (cnt_clr) begin
      sbit_cnt_d = '0;
      dbit_cnt_d = '0;
    end else begin
      if (xfer && sbit_q && !(&sbit_cnt_q)) sbit_cnt_d = sbit_cnt_q + CNT_WIDTH'(1);
      if (xfer && dbit_q && !(&dbit_cnt_q)) dbit_cnt_d = dbit_cnt_q + CNT_WIDTH'(1);
    end
    if (err_log_clr) begin
      log_valid_d = 1'b0;
      log_syn_d   = '0;
    end else if (xfer && (sbit_q || dbit_q) && !log_valid_q) begin
      log_valid_d = 1'b1;
      log_syn_d   = syn_q;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sbit_cnt_q  <= '0;
      dbit_cnt_q  <= '0;
      log_valid_q <= 1'b0;
      log_syn_q   <= '0;
    end else begin
      sbit_cnt_q  <= sbit_cnt_d;
      dbit_cnt_q  <= dbit_cnt_d;
      log_valid_q <= log_valid_d;
      log_syn_q   <= log_syn_d;
    end
  end

  assign sbit_cnt         = sbit_cnt_q;
  assign dbit_cnt         = dbit_cnt_q;
  assign err_log_valid    = log_valid_q;
  assign err_log_syndrome = log_syn_q;

endmodule

// File: tb/tb_ecc_secded_pipe.sv
// tb/tb_ecc_secded_pipe.sv - directed self-checking bench for ecc_secded_pipe
module tb_ecc_secded_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        enc_valid_in;
  logic [31:0] enc_data_in;
  logic        enc_valid_out;
  logic [31:0] enc_data_out;
  logic [6:0]  enc_parity_out;
  logic        dec_valid_in;
  logic        dec_ready_out;
  logic [31:0] dec_data_in;
  logic [6:0]  dec_parity_in;
  logic        bypass;
  logic        dec_valid_out;
  logic        dec_ready_in;
  logic [31:0] dec_data_out;
  logic        sbit_err;
  logic        dbit_err;
  logic [6:0]  err_syndrome;
  logic [3:0]  sbit_cnt;
  logic [3:0]  dbit_cnt;
  logic        cnt_clr;
  logic        err_log_valid;
  logic [6:0]  err_log_syndrome;
  logic        err_log_clr;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  ecc_secded_pipe #(.DATA_WIDTH(32), .PARITY_WIDTH(7), .CNT_WIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .enc_valid_in(enc_valid_in), .enc_data_in(enc_data_in),
    .enc_valid_out(enc_valid_out), .enc_data_out(enc_data_out), .enc_parity_out(enc_parity_out),
    .dec_valid_in(dec_valid_in), .dec_ready_out(dec_ready_out),
    .dec_data_in(dec_data_in), .dec_parity_in(dec_parity_in), .bypass(bypass),
    .dec_valid_out(dec_valid_out), .dec_ready_in(dec_ready_in), .dec_data_out(dec_data_out),
    .sbit_err(sbit_err), .dbit_err(dbit_err), .err_syndrome(err_syndrome),
    .sbit_cnt(sbit_cnt), .dbit_cnt(dbit_cnt), .cnt_clr(cnt_clr),
    .err_log_valid(err_log_valid), .err_log_syndrome(err_log_syndrome), .err_log_clr(err_log_clr)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference codeword: cw[0] is overall parity, cw[1..38] are Hamming positions.
  function automatic logic [38:0] model_cw(input logic [31:0] d);
    logic [38:0] cw;
    logic [5:0]  syn;
    int          idx;
    cw  = '0;
    syn = '0;
    idx = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        cw[p] = d[idx];
        if (d[idx]) syn = syn ^ 6'(p);
        idx++;
      end
    end
    for (int k = 0; k < 6; k++) cw[1 << k] = syn[k];
    cw[0] = ^cw[38:1];
    return cw;
  endfunction

  function automatic logic [31:0] cw_data(input logic [38:0] cw);
    logic [31:0] d;
    int          idx;
    d   = '0;
    idx = 0;
    for (int p = 1; p <= 38; p++) begin
      if ((p & (p - 1)) != 0) begin
        d[idx] = cw[p];
        idx++;
      end
    end
    return d;
  endfunction

  function automatic logic [6:0] cw_par(input logic [38:0] cw);
    logic [6:0] par;
    for (int k = 0; k < 6; k++) par[k] = cw[1 << k];
    par[6] = cw[0];
    return par;
  endfunction

  task automatic run_enc(input logic [31:0] d, input logic [6:0] exp_par);
    enc_data_in  = d;
    enc_valid_in = 1'b1;
    @(posedge clk); #1;
    enc_valid_in = 1'b0;
    check("enc_vld", enc_valid_out, 1'b1);
    check("enc_data", enc_data_out, d);
    check("enc_par", enc_parity_out, exp_par);
    @(posedge clk); #1;
    check("enc_vld_drop", enc_valid_out, 1'b0);
  endtask

  // One word through the decoder with dec_ready_in held high; clr asserts both
  // clears in the cycle the word transfers out.
  task automatic run_dec(input logic [31:0] d, input logic [6:0] p, input logic byp, input logic clr,
                         output logic [31:0] od, output logic osb, output logic odb,
                         output logic [6:0] osyn);
    dec_data_in   = d;
    dec_parity_in = p;
    bypass        = byp;
    dec_valid_in  = 1'b1;
    @(posedge clk); #1;
    dec_valid_in = 1'b0;
    bypass       = 1'b0;
    @(posedge clk); #1;
    check("dec_vld", dec_valid_out, 1'b1);
    od   = dec_data_out;
    osb  = sbit_err;
    odb  = dbit_err;
    osyn = err_syndrome;
    cnt_clr     = clr;
    err_log_clr = clr;
    @(posedge clk); #1;
    cnt_clr     = 1'b0;
    err_log_clr = 1'b0;
  endtask

  task automatic pulse_cnt_clr();
    cnt_clr = 1'b1;
    @(posedge clk); #1;
    cnt_clr = 1'b0;
  endtask

  logic [31:0] od, w;
  logic        osb, odb;
  logic [6:0]  osyn;
  logic [38:0] cw, cwf;
  logic [31:0] seen [4];
  logic [31:0] wa, wb, wc;
  int          got;

  initial begin
    rst = 1'b1;
    enc_valid_in = 1'b0; enc_data_in = '0;
    dec_valid_in = 1'b0; dec_data_in = '0; dec_parity_in = '0; bypass = 1'b0;
    dec_ready_in = 1'b1; cnt_clr = 1'b0; err_log_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_enc_vld", enc_valid_out, 1'b0);
    check("rst_dec_vld", dec_valid_out, 1'b0);
    check("rst_sbit_cnt", sbit_cnt, 4'd0);
    check("rst_log_vld", err_log_valid, 1'b0);
    @(posedge clk); #1;
    check("rst_ready", dec_ready_out, 1'b1);

    // Encoder: hand-computed vectors, then a few against the reference model
    run_enc(32'h0000_0000, 7'h00);
    run_enc(32'h0000_0001, 7'h43);
    run_enc(32'h0000_0003, 7'h06);
    run_enc(32'hDEAD_BEEF, cw_par(model_cw(32'hDEAD_BEEF)));
    run_enc(32'hFFFF_FFFF, cw_par(model_cw(32'hFFFF_FFFF)));

    // Single error on d0 -> corrected
    run_dec(32'h0000_0001, 7'h00, 1'b0, 1'b0, od, osb, odb, osyn);
    check("se_data", od, 32'h0);
    check("se_sbit", osb, 1'b1);
    check("se_dbit", odb, 1'b0);
    check("se_syn", osyn, 7'h43);
    check("se_cnt", sbit_cnt, 4'd1);
    check("se_log_vld", err_log_valid, 1'b1);
    check("se_log_syn", err_log_syndrome, 7'h43);

    // Double error -> flagged, data untouched, log keeps first entry
    run_dec(32'h0000_0003, 7'h00, 1'b0, 1'b0, od, osb, odb, osyn);
    check("de_data", od, 32'h3);
    check("de_dbit", odb, 1'b1);
    check("de_sbit", osb, 1'b0);
    check("de_syn", osyn, 7'h06);
    check("de_cnt", dbit_cnt, 4'd1);
    check("de_log_syn", err_log_syndrome, 7'h43);

    // Clean word
    cw = model_cw(32'hDEAD_BEEF);
    run_dec(cw_data(cw), cw_par(cw), 1'b0, 1'b0, od, osb, odb, osyn);
    check("clean_data", od, 32'hDEAD_BEEF);
    check("clean_flags", {osb, odb}, 2'b00);
    check("clean_syn", osyn, 7'h00);
    check("clean_cnt", {sbit_cnt, dbit_cnt}, 8'h11);

    // Clears win over an error transferring in the same cycle
    run_dec(32'h0000_0001, 7'h00, 1'b0, 1'b1, od, osb, odb, osyn);
    check("clr_sbit_cnt", sbit_cnt, 4'd0);
    check("clr_dbit_cnt", dbit_cnt, 4'd0);
    check("clr_log_vld", err_log_valid, 1'b0);

    // Bypass with bad parity: untouched, no flags, not counted or logged
    run_dec(32'h0000_0003, 7'h00, 1'b1, 1'b0, od, osb, odb, osyn);
    check("byp_data", od, 32'h3);
    check("byp_flags", {osb, odb}, 2'b00);
    check("byp_syn", osyn, 7'h00);
    check("byp_cnt", {sbit_cnt, dbit_cnt}, 8'h00);
    check("byp_log", err_log_valid, 1'b0);

    // Log captures a fresh first error after clear
    run_dec(32'h0000_0003, 7'h00, 1'b0, 1'b0, od, osb, odb, osyn);
    check("relog_vld", err_log_valid, 1'b1);
    check("relog_syn", err_log_syndrome, 7'h06);

    // Every single-bit flip of a codeword is corrected
    w  = 32'hA5C3_960F;
    cw = model_cw(w);
    for (int b = 0; b < 39; b++) begin
      cwf    = cw;
      cwf[b] = ~cwf[b];
      run_dec(cw_data(cwf), cw_par(cwf), 1'b0, 1'b0, od, osb, odb, osyn);
      check($sformatf("flip1_data_%0d", b), od, w);
      check($sformatf("flip1_sbit_%0d", b), osb, 1'b1);
    end
    // Two-bit flips are detected
    for (int b = 0; b < 13; b++) begin
      cwf = cw;
      cwf[b * 3]             = ~cwf[b * 3];
      cwf[(b * 3 + 7) % 39]  = ~cwf[(b * 3 + 7) % 39];
      run_dec(cw_data(cwf), cw_par(cwf), 1'b0, 1'b0, od, osb, odb, osyn);
      check($sformatf("flip2_dbit_%0d", b), odb, 1'b1);
      check($sformatf("flip2_sbit_%0d", b), osb, 1'b0);
    end
    pulse_cnt_clr();

    // Backpressure: three correctable words offered while the sink stalls
    wa = 32'h1111_1111; wb = 32'h2222_2222; wc = 32'h3333_3333;
    dec_ready_in = 1'b0;
    dec_valid_in = 1'b1;
    dec_data_in = wa ^ 32'h1; dec_parity_in = cw_par(model_cw(wa));
    @(posedge clk); #1;
    dec_data_in = wb ^ 32'h1; dec_parity_in = cw_par(model_cw(wb));
    @(posedge clk); #1;
    dec_data_in = wc ^ 32'h1; dec_parity_in = cw_par(model_cw(wc));
    check("stall_ready", dec_ready_out, 1'b0);
    check("stall_vld", dec_valid_out, 1'b1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      check($sformatf("stall_hold_%0d", c), dec_data_out, wa);
      check($sformatf("stall_rdy_%0d", c), dec_ready_out, 1'b0);
    end
    check("stall_no_cnt", sbit_cnt, 4'd0);
    dec_ready_in = 1'b1;
    got = 0;
    for (int c = 0; c < 6; c++) begin
      if (dec_valid_out && got < 4) begin
        seen[got] = dec_data_out;
        got++;
      end
      @(posedge clk); #1;
      dec_valid_in = 1'b0;
    end
    check("stall_count", got, 3);
    check("stall_w0", seen[0], wa);
    check("stall_w1", seen[1], wb);
    check("stall_w2", seen[2], wc);
    check("stall_cnt", sbit_cnt, 4'd3);
    pulse_cnt_clr();

    // Saturation with a 4-bit counter
    for (int i = 0; i < 20; i++) begin
      run_dec(32'h0000_0001, 7'h00, 1'b0, 1'b0, od, osb, odb, osyn);
      if (i == 14) check("sat_15", sbit_cnt, 4'd15);
    end
    check("sat_20", sbit_cnt, 4'd15);

    // Reset while the pipeline is full and stalled
    dec_ready_in = 1'b0;
    dec_valid_in = 1'b1;
    dec_data_in = 32'h0000_0001; dec_parity_in = 7'h00;
    enc_valid_in = 1'b1; enc_data_in = 32'h0000_0001;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("pre_rst_vld", dec_valid_out, 1'b1);
    rst = 1'b1;
    enc_valid_in = 1'b0;
    dec_valid_in = 1'b0;
    @(posedge clk); #1;
    check("mrst_enc", {enc_valid_out, enc_data_out, enc_parity_out}, 40'h0);
    check("mrst_dec", {dec_valid_out, dec_data_out}, 33'h0);
    check("mrst_flags", {sbit_err, dbit_err, err_syndrome}, 9'h0);
    check("mrst_cnt", {sbit_cnt, dbit_cnt}, 8'h00);
    check("mrst_log", {err_log_valid, err_log_syndrome}, 8'h00);
    rst = 1'b0;
    dec_ready_in = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", dec_ready_out, 1'b1);
    got = 0;
    for (int c = 0; c < 4; c++) begin
      if (dec_valid_out) got++;
      @(posedge clk); #1;
    end
    check("post_rst_no_out", got, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/ecc_secded_pipe.md
Name: ecc_secded_pipe

Overview:
- Parametrised, pipelined SECDED (extended Hamming) encoder/decoder for FIFO and RAM data paths of any width; successor to the fixed 12-bit combinational ECC.
- Registered 1-cycle encoder, 2-stage decoder with valid/ready flow control, per-word bypass, saturating error counters and a first-error syndrome log for status reporting.

Parameters:
- DATA_WIDTH, 32, data bits per word (>=4).
- PARITY_WIDTH, 7, check bits = r+1, where r is the smallest value with 2^r >= DATA_WIDTH+r+1 (12->6, 32->7, 64->8). Any other value is an elaboration error.
- CNT_WIDTH, 16, width of each error counter.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- enc_valid_in  in  1  encode request
- enc_data_in  in  DATA_WIDTH  data to encode
- enc_valid_out  out  1  encode result valid
- enc_data_out  out  DATA_WIDTH  registered copy of enc_data_in
- enc_parity_out  out  PARITY_WIDTH  generated check bits
- dec_valid_in  in  1  decode word valid
- dec_ready_out  out  1  decoder can accept
- dec_data_in  in  DATA_WIDTH  received data
- dec_parity_in  in  PARITY_WIDTH  received check bits
- bypass  in  1  per-word: pass data through, no correction
- dec_valid_out  out  1  decoded word valid
- dec_ready_in  in  1  downstream accepts
- dec_data_out  out  DATA_WIDTH  corrected data
- sbit_err  out  1  single-bit error corrected (qualified by dec_valid_out)
- dbit_err  out  1  uncorrectable error
- err_syndrome  out  PARITY_WIDTH  syndrome of the output word
- sbit_cnt  out  CNT_WIDTH  saturating single-error count
- dbit_cnt  out  CNT_WIDTH  saturating double-error count
- cnt_clr  in  1  clear both counters
- err_log_valid  out  1  log holds an entry
- err_log_syndrome  out  PARITY_WIDTH  syndrome of first logged error
- err_log_clr  in  1  clear the log

Behaviour:
- Code: codeword positions 1..DATA_WIDTH+r. Check bit k sits at position 2^k. Data bits fill the remaining positions in ascending order (d0 at position 3, d1 at 5, d2 at 6, d3 at 7, d4 at 9, ...).
- Parity layout: parity[k] (k<r) = XOR of data bits whose position has bit k set. parity[r] = XOR of all data and parity[r-1:0].
- Encoder: on enc_valid_in, the next cycle drives enc_data_out, enc_parity_out and enc_valid_out=1; otherwise enc_valid_out=0. The encoder has no backpressure.
- Decoder stage 1: computes h = dec_parity_in[r-1:0] ^ recomputed checks, and p = XOR of all received data and parity bits. Registers data, h, p, bypass and valid.
- Decoder stage 2: classifies the word and registers the outputs.
  - h=0, p=0: clean.
  - p=1, h=0 or h a power of two: parity bit error; sbit=1, data unchanged.
  - p=1, h a data position: flip that data bit; sbit=1.
  - p=1, h > DATA_WIDTH+r: dbit=1.
  - p=0, h!=0: dbit=1, data unchanged.
  - err_syndrome = {p,h}.
- Latency: 2 cycles from accept to dec_valid_out when there is no stall.
- Flow control: en = ~dec_valid_out | dec_ready_in. dec_ready_out = en. Both stages advance only when en=1, so a stall freezes the whole pipeline with outputs held stable. Bubbles are not collapsed.
- A word is accepted when dec_valid_in & dec_ready_out, and transfers out when dec_valid_out & dec_ready_in.
- Bypass words: data passes unchanged, sbit=dbit=0, err_syndrome=0, not counted, not logged.
- Counters: increment on output transfer of an sbit/dbit word and saturate at all-ones. cnt_clr has priority over increment in the same cycle (result 0).
- Log: on transfer of the first sbit/dbit word while err_log_valid=0, captures the syndrome and sets err_log_valid. Later errors are ignored until err_log_clr. err_log_clr has priority; an error in the same cycle is not logged.
- Reset: every output is 0, all valids are 0, counters and log are 0, and in-flight words are discarded. dec_ready_out reads 1 from the cycle after reset.
- Reset mid-stall: drops held words; no output transfer occurs.

Test Plan:
- Encode (DATA_WIDTH=32) 0x00000000 -> parity 0x00; encode 0x00000001 -> parity 0x43, enc_valid_out one cycle later.
- Decode data=0x00000001, parity=0x00 -> 2 cycles later data_out=0x00000000, sbit_err=1, err_syndrome=0x43, sbit_cnt=1, log captures 0x43.
- Decode data=0x00000003, parity=0x00 -> data_out=0x00000003, dbit_err=1, err_syndrome=0x06, dbit_cnt=1; log unchanged if already valid.
- Flip each of the 39 codeword bits of an encoded random word -> data restored, sbit=1 every time. Any 2-bit flip -> dbit=1.
- Hold dec_ready_in=0 for 5 cycles with 3 words offered -> dec_ready_out=0 after the pipe fills, outputs stable, no word lost or duplicated, counters increment once per word.
- With CNT_WIDTH=4: 20 single-error words -> sbit_cnt=15. Assert cnt_clr together with an error word -> 0. Bypass word with bad parity -> unchanged data, no flags. Reset mid-stream -> all outputs 0 next cycle.
